// File: rtl/z_core_pkg.sv
// Shared definitions for the core: instruction codes seen by the ALU control
// decoder, the ALU and the divide unit, plus the divide sequencer states.
package z_core_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] INST_DIV  = 5'd20;
   localparam logic [4:0] INST_DIVU = 5'd21;
   localparam logic [4:0] INST_REM  = 5'd22;
   localparam logic [4:0] INST_REMU = 5'd23;

   localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES   = {XLEN{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX,
      ST_SPECIAL,
      ST_DONE
   } divState_t;

endpackage

// File: rtl/z_core_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module z_core_div_step
   import z_core_pkg::*;
#(
   parameter int STEP_XLEN = z_core_pkg::XLEN
) (
   input  logic [STEP_XLEN:0]   i_rem,
   input  logic [STEP_XLEN-1:0] i_dvd,
   input  logic [STEP_XLEN-1:0] i_divisor,
   output logic [STEP_XLEN:0]   o_remNext,
   output logic [STEP_XLEN-1:0] o_dvdNext,
   output logic                 o_qBit
);

   logic [STEP_XLEN:0] w_shift;
   logic [STEP_XLEN:0] w_diff;

   // Shift/compare/subtract; a set carry bit in the old remainder would mean
   // the shifted value certainly exceeds the divisor, so it forces a 1 bit.
   always_comb begin
      w_shift   = {i_rem[STEP_XLEN-1:0], i_dvd[STEP_XLEN-1]};
      w_diff    = w_shift - {1'b0, i_divisor};
      o_qBit    = i_rem[STEP_XLEN] | (w_shift >= {1'b0, i_divisor});
      o_remNext = o_qBit ? w_diff : w_shift;
      o_dvdNext = {i_dvd[STEP_XLEN-2:0], 1'b0};
   end

endmodule

// File: rtl/z_core_div_unit.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU). Works on magnitudes with
// a restoring divider and fixes signs at the end; divide-by-zero and signed
// overflow skip the iterations entirely.
module z_core_div_unit
   import z_core_pkg::*;
#(
   parameter int XLEN = z_core_pkg::XLEN
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_start,
   input  logic [4:0]      i_inst_type,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   // Special-case constants follow this instance's width rather than the package default.
   localparam logic [XLEN-1:0] DIV_SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] DIV_ALL_ONES   = {XLEN{1'b1}};
   localparam logic [5:0]      CNT_INIT       = 6'(XLEN - 1);

   divState_t       r_state;
   divState_t       w_nextState;

   logic [XLEN:0]   r_rem;
   logic [XLEN-1:0] r_dvd;
   logic [XLEN-1:0] r_div;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_opA;
   logic [XLEN-1:0] r_result;
   logic [5:0]      r_cnt;
   logic            r_isRem;
   logic            r_qNeg;
   logic            r_rNeg;
   logic            r_divZero;

   logic            w_validOp;
   logic            w_isSignedIn;
   logic            w_isRemIn;
   logic            w_aNeg;
   logic            w_bNeg;
   logic            w_divZero;
   logic            w_overflow;
   logic            w_accept;
   logic [XLEN-1:0] w_absA;
   logic [XLEN-1:0] w_absB;
   logic [XLEN-1:0] w_quoFix;
   logic [XLEN-1:0] w_remFix;
   logic [XLEN-1:0] w_fixRes;
   logic [XLEN-1:0] w_specRes;

   logic [XLEN:0]   w_remNext;
   logic [XLEN-1:0] w_dvdNext;
   logic            w_qBit;

   // Decode the request and form operand magnitudes; flush beats a same-cycle start.
   always_comb begin
      w_validOp    = (i_inst_type == INST_DIV) || (i_inst_type == INST_DIVU) ||
                     (i_inst_type == INST_REM) || (i_inst_type == INST_REMU);
      w_isSignedIn = (i_inst_type == INST_DIV) || (i_inst_type == INST_REM);
      w_isRemIn    = (i_inst_type == INST_REM) || (i_inst_type == INST_REMU);
      w_aNeg       = w_isSignedIn & i_op_a[XLEN-1];
      w_bNeg       = w_isSignedIn & i_op_b[XLEN-1];
      w_absA       = w_aNeg ? -i_op_a : i_op_a;
      w_absB       = w_bNeg ? -i_op_b : i_op_b;
      w_divZero    = (i_op_b == '0);
      w_overflow   = w_isSignedIn && (i_op_a == DIV_SIGNED_MIN) && (i_op_b == DIV_ALL_ONES);
      w_accept     = (r_state == ST_IDLE) && i_start && w_validOp && !i_flush;
   end

   z_core_div_step #(
      .STEP_XLEN (XLEN)
   ) u_step (
      .i_rem     (r_rem),
      .i_dvd     (r_dvd),
      .i_divisor (r_div),
      .o_remNext (w_remNext),
      .o_dvdNext (w_dvdNext),
      .o_qBit    (w_qBit)
   );

   // Final sign correction and the one-cycle answers for the special cases.
   always_comb begin
      w_quoFix  = r_qNeg ? -r_quo : r_quo;
      w_remFix  = r_rNeg ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
      w_fixRes  = r_isRem ? w_remFix : w_quoFix;
      if (r_divZero) begin
         w_specRes = r_isRem ? r_opA : DIV_ALL_ONES;
      end else begin
         w_specRes = r_isRem ? '0 : DIV_SIGNED_MIN;
      end
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic and handshake outputs; flush drops any live operation.
   always_comb begin
      w_nextState = r_state;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_nextState = (w_divZero || w_overflow) ? ST_SPECIAL : ST_CALC;
            end
         end
         ST_CALC: begin
            o_busy = 1'b1;
            if (i_flush) begin
               w_nextState = ST_IDLE;
            end else if (r_cnt == 6'd0) begin
               w_nextState = ST_FIX;
            end
         end
         ST_FIX, ST_SPECIAL: begin
            o_busy      = 1'b1;
            w_nextState = i_flush ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            o_done      = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // Datapath: capture on accept, iterate in CALC, and load the result on the
   // way into DONE so it only changes when done is shown.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_rem     <= '0;
         r_dvd     <= '0;
         r_div     <= '0;
         r_quo     <= '0;
         r_opA     <= '0;
         r_result  <= '0;
         r_cnt     <= '0;
         r_isRem   <= 1'b0;
         r_qNeg    <= 1'b0;
         r_rNeg    <= 1'b0;
         r_divZero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_rem     <= '0;
                  r_dvd     <= w_absA;
                  r_div     <= w_absB;
                  r_quo     <= '0;
                  r_opA     <= i_op_a;
                  r_cnt     <= CNT_INIT;
                  r_isRem   <= w_isRemIn;
                  r_qNeg    <= w_aNeg ^ w_bNeg;
                  r_rNeg    <= w_aNeg;
                  r_divZero <= w_divZero;
               end
            end
            ST_CALC: begin
               r_rem <= w_remNext;
               r_dvd <= w_dvdNext;
               r_quo <= {r_quo[XLEN-2:0], w_qBit};
               if (r_cnt != 6'd0) begin
                  r_cnt <= r_cnt - 6'd1;
               end
            end
            ST_FIX: begin
               if (!i_flush) begin
                  r_result <= w_fixRes;
               end
            end
            ST_SPECIAL: begin
               if (!i_flush) begin
                  r_result <= w_specRes;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_result = r_result;

endmodule
